// File: rtl/program_image_loader.sv
// program_image_loader: boot-time loader that unpacks a 32-bit word stream into
// little-endian byte writes and holds the core in reset until the image is in memory.
// Define LOADER_ZERO_FILL_EN to zero the memory tail after the last image byte.
module program_image_loader #(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              overflow,
  output logic [ADDR_W-2:0] word_count
);

`ifdef LOADER_ZERO_FILL_EN
  typedef enum logic [1:0] {ST_ACCEPT, ST_WRITE, ST_FILL, ST_DONE} state_e;
`else
  typedef enum logic [1:0] {ST_ACCEPT, ST_WRITE, ST_DONE} state_e;
`endif

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-2:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              load_done_q, load_done_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W-2:0] word_count_q, word_count_d;
  logic [ADDR_W-1:0] addr_next;

  always_comb begin
    // NOTE: every signal gets its hold/idle value first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    last_d       = last_q;
    in_ready_d   = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_reset_d  = cpu_reset_q;
    load_done_d  = load_done_q;
    overflow_d   = overflow_q;
    word_count_d = word_count_q;
    addr_next    = mem_addr_q + 1'b1;

    case (state_q)
      ST_ACCEPT: begin
        if (in_valid && in_ready_q) begin
          word_d      = in_data;
          last_d      = in_last;
          byte_idx_d  = 2'd0;
          mem_we_d    = 1'b1;
          mem_wdata_d = in_data[7:0];
          state_d     = ST_WRITE;
          if (word_count_q != CNT_MAX) word_count_d = word_count_q + 1'b1;
        end else begin
          in_ready_d = 1'b1;
        end
      end

      ST_WRITE: begin
        mem_addr_d = addr_next;
        if (byte_idx_q != 2'd3) begin
          byte_idx_d  = byte_idx_q + 2'd1;
          mem_we_d    = 1'b1;
          mem_wdata_d = word_q[{byte_idx_d, 3'b000} +: 8];
        end else if (last_q) begin
`ifdef LOADER_ZERO_FILL_EN
          // A wrapped address means the image already ends at the top of memory.
          if (addr_next != '0) begin
            state_d     = ST_FILL;
            mem_we_d    = 1'b1;
            mem_wdata_d = 8'h00;
          end else begin
            state_d     = ST_DONE;
            load_done_d = 1'b1;
          end
`else
          state_d     = ST_DONE;
          load_done_d = 1'b1;
`endif
        end else if (addr_next == '0) begin
          state_d     = ST_DONE;
          load_done_d = 1'b1;
          overflow_d  = 1'b1;
        end else begin
          state_d    = ST_ACCEPT;
          in_ready_d = 1'b1;
        end
      end

`ifdef LOADER_ZERO_FILL_EN
      ST_FILL: begin
        if (mem_addr_q == '1) begin
          state_d     = ST_DONE;
          load_done_d = 1'b1;
        end else begin
          mem_addr_d  = addr_next;
          mem_we_d    = 1'b1;
          mem_wdata_d = 8'h00;
        end
      end
`endif

      ST_DONE: begin
        cpu_reset_d = 1'b0;
      end

      default: begin
        state_d = ST_ACCEPT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (reset) begin
      state_q      <= ST_ACCEPT;
      byte_idx_q   <= 2'd0;
      word_q       <= 32'h0;
      last_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= BASE;
      mem_wdata_q  <= 8'h00;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      last_q       <= last_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      overflow_q   <= overflow_d;
      word_count_q <= word_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign load_done  = load_done_q;
  assign overflow   = overflow_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_program_image_loader.sv
// tb_program_image_loader: directed bench with a 4 KiB loader (a_*) and a 16-byte
// loader (b_*); byte writes are mirrored into bench arrays for content checks.
module tb_program_image_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_in_valid, a_in_last, a_in_ready, a_mem_we;
  logic [31:0] a_in_data;
  logic [11:0] a_mem_addr;
  logic [7:0]  a_mem_wdata;
  logic        a_cpu_reset, a_load_done, a_overflow;
  logic [10:0] a_word_count;

  logic        b_reset, b_in_valid, b_in_last, b_in_ready, b_mem_we;
  logic [31:0] b_in_data;
  logic [3:0]  b_mem_addr;
  logic [7:0]  b_mem_wdata;
  logic        b_cpu_reset, b_load_done, b_overflow;
  logic [2:0]  b_word_count;

  program_image_loader #(.ADDR_W(12), .BASE_ADDR(0)) u_dut_a (
    .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_last(a_in_last), .in_ready(a_in_ready), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .cpu_reset(a_cpu_reset),
    .load_done(a_load_done), .overflow(a_overflow), .word_count(a_word_count)
  );

  program_image_loader #(.ADDR_W(4), .BASE_ADDR(0)) u_dut_b (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_last(b_in_last), .in_ready(b_in_ready), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .cpu_reset(b_cpu_reset),
    .load_done(b_load_done), .overflow(b_overflow), .word_count(b_word_count)
  );

  logic [7:0] mem_a [4096];
  logic [7:0] mem_b [16];
  int wr_a = 0;
  int wr_b = 0;

  always @(negedge clk) begin
    if (a_mem_we) begin mem_a[a_mem_addr] = a_mem_wdata; wr_a++; end
    if (b_mem_we) begin mem_b[b_mem_addr] = b_mem_wdata; wr_b++; end
  end

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] seq_word(input int i);
    logic [7:0] b0;
    b0 = 8'(4 * i);
    return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
  endfunction

  // Streams seq_word(0..n-1) on the b side with in_valid held high.
  task automatic stream_b(input int n_words, input bit last_at_end, output int n_acc);
    bit acc;
    n_acc      = 0;
    b_in_valid = 1'b1;
    b_in_data  = seq_word(0);
    b_in_last  = last_at_end && (n_words == 1);
    for (int c = 0; c < 100 && n_acc < n_words && !b_load_done; c++) begin
      acc = b_in_valid && b_in_ready;
      tick();
      if (acc) begin
        n_acc++;
        if (n_acc < n_words) begin
          b_in_data = seq_word(n_acc);
          b_in_last = last_at_end && (n_acc == n_words - 1);
        end else begin
          b_in_valid = 1'b0;
        end
      end
    end
    for (int c = 0; c < 50 && !b_load_done; c++) tick();
  endtask

  logic [31:0] exp_word;
  int          acc_cyc [3];
  int          idx, n_acc;
  bit          acc, hit;

  initial begin
    a_reset = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0;
    b_reset = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0;

    // 1. reset values, then one word with last
    repeat (3) tick();
    check("rst_in_ready",   a_in_ready,   0);
    check("rst_mem_we",     a_mem_we,     0);
    check("rst_mem_addr",   a_mem_addr,   0);
    check("rst_mem_wdata",  a_mem_wdata,  0);
    check("rst_cpu_reset",  a_cpu_reset,  1);
    check("rst_load_done",  a_load_done,  0);
    check("rst_overflow",   a_overflow,   0);
    check("rst_word_count", a_word_count, 0);
    check("rst_b_cpu_reset", b_cpu_reset, 1);

    a_reset = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hA1B2C3D4; a_in_last = 1'b1;
    tick();
    check("t1_ready_up", a_in_ready, 1);
    check("t1_no_we",    a_mem_we,   0);
    tick();
    a_in_valid = 1'b0;
    exp_word = 32'hA1B2C3D4;
    for (int k = 0; k < 4; k++) begin
      check("t1_we",    a_mem_we,    1);
      check("t1_addr",  a_mem_addr,  k);
      check("t1_wdata", a_mem_wdata, exp_word[8*k +: 8]);
      check("t1_ready", a_in_ready,  0);
      tick();
    end
`ifdef LOADER_ZERO_FILL_EN
    check("t1_fill_we",    a_mem_we,    1);
    check("t1_fill_addr",  a_mem_addr,  4);
    check("t1_fill_wdata", a_mem_wdata, 0);
    for (int c = 0; c < 5000 && !a_load_done; c++) tick();
`endif
    check("t1_load_done",  a_load_done,  1);
    check("t1_done_we",    a_mem_we,     0);
    check("t1_word_count", a_word_count, 1);
    check("t1_cpu_rst_hi", a_cpu_reset,  1);
    a_in_valid = 1'b1;
    tick();
    check("t1_cpu_rst_lo", a_cpu_reset,  0);
    tick();
    check("t1_done_ready", a_in_ready,   0);
    check("t1_done_count", a_word_count, 1);

    // 2. three back-to-back words, in_valid held high
    a_in_valid = 1'b0; a_reset = 1'b1;
    tick();
    a_reset = 1'b0; wr_a = 0;
    idx = 0;
    a_in_valid = 1'b1; a_in_data = seq_word(0); a_in_last = 1'b0;
    for (int c = 0; c < 60 && idx < 3; c++) begin
      acc = a_in_valid && a_in_ready;
      tick();
      if (acc) begin
        acc_cyc[idx] = c;
        idx++;
        if (idx < 3) begin a_in_data = seq_word(idx); a_in_last = (idx == 2); end
        else a_in_valid = 1'b0;
      end
    end
    for (int c = 0; c < 5000 && !a_load_done; c++) tick();
    check("t2_accepts", idx, 3);
    check("t2_gap01", acc_cyc[1] - acc_cyc[0], 5);
    check("t2_gap12", acc_cyc[2] - acc_cyc[1], 5);
    for (int j = 0; j < 12; j++) check("t2_byte", mem_a[j], j);
    check("t2_word_count", a_word_count, 3);
    check("t2_load_done",  a_load_done,  1);
    check("t2_overflow",   a_overflow,   0);
`ifdef LOADER_ZERO_FILL_EN
    check("t2_writes", wr_a, 4096);
`else
    check("t2_writes", wr_a, 12);
`endif

    // 3. 16-byte memory, five words without last
    b_reset = 1'b0; wr_b = 0;
    stream_b(5, 1'b0, n_acc);
    check("t3_accepts",   n_acc,        4);
    check("t3_overflow",  b_overflow,   1);
    check("t3_load_done", b_load_done,  1);
    check("t3_count",     b_word_count, 4);
    check("t3_valid_hi",  b_in_valid,   1);
    for (int j = 0; j < 16; j++) check("t3_byte", mem_b[j], j);
    repeat (10) tick();
    check("t3_ready_lo",  b_in_ready,   0);
    check("t3_count_hold", b_word_count, 4);
    check("t3_writes",    wr_b,         16);

    // 4. 16-byte memory, last on the 4th word
    b_in_valid = 1'b0; b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    stream_b(4, 1'b1, n_acc);
    check("t4_accepts",   n_acc,        4);
    check("t4_load_done", b_load_done,  1);
    check("t4_overflow",  b_overflow,   0);
    check("t4_count",     b_word_count, 4);

    // 5. reset during the k=2 byte of word 2
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    idx = 0; hit = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'h11223344; a_in_last = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      acc = a_in_valid && a_in_ready;
      tick();
      if (acc) begin idx++; a_in_data = 32'h55667788; end
      hit = a_mem_we && (a_mem_addr == 12'd6);
    end
    check("t5_hit",      hit,         1);
    check("t5_k2_wdata", a_mem_wdata, 8'h66);
    a_reset = 1'b1;
    tick();
    check("t5_we",        a_mem_we,     0);
    check("t5_cpu_reset", a_cpu_reset,  1);
    check("t5_count",     a_word_count, 0);
    check("t5_addr",      a_mem_addr,   0);
    check("t5_ready",     a_in_ready,   0);
    a_reset = 1'b0; a_in_data = 32'hCAFEF00D; a_in_last = 1'b1;
    tick();
    tick();
    a_in_valid = 1'b0;
    check("t5_reload_we",    a_mem_we,     1);
    check("t5_reload_addr",  a_mem_addr,   0);
    check("t5_reload_wdata", a_mem_wdata,  8'h0D);
    check("t5_reload_count", a_word_count, 1);

    // 6. 16-byte memory, single word with last, then tail handling
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0; b_in_valid = 1'b1; b_in_data = 32'hDEADBEEF; b_in_last = 1'b1;
    tick();
    tick();
    b_in_valid = 1'b0;
    repeat (3) tick();
    check("t6_last_addr",  b_mem_addr,  3);
    check("t6_last_wdata", b_mem_wdata, 8'hDE);
    tick();
`ifdef LOADER_ZERO_FILL_EN
    for (int i = 0; i < 12; i++) begin
      check("t6_fill_we",    b_mem_we,    1);
      check("t6_fill_addr",  b_mem_addr,  4 + i);
      check("t6_fill_wdata", b_mem_wdata, 0);
      check("t6_fill_busy",  b_load_done, 0);
      tick();
    end
`else
    check("t6_done_addr", b_mem_addr, 4);
`endif
    check("t6_load_done", b_load_done, 1);
    check("t6_done_we",   b_mem_we,    0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
